// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write-beat generator: burst encodings,
// response codes and the beat-generator FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  // Reserved encoding; the generator treats it as INCR and reports an error.
  localparam logic [1:0] BURST_RSVD = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_t;

  // A WRAP burst must be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_next.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// The burst input is expected to be already normalised (no reserved code,
// WRAP only with a legal length).
module axi_addr_next
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // Select the following beat address; INCR wraps modulo 2^ADDR_WIDTH naturally.
  always_comb begin
    beat_bytes = ADDR_WIDTH'(1) << size;
    incr_addr  = addr + beat_bytes;
    wrap_mask  = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    next_addr  = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_wr_beat_gen.sv
// AXI write-burst to per-beat cache-write converter. Accepts one merged AW
// at a time, streams each W beat to the cache port with its own address,
// then returns a single B response (SLVERR if anything about the burst was
// malformed).
module axi_wr_beat_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [1:0]              s_awburst,
  input  logic [2:0]              s_awsize,
  input  logic [7:0]              s_awlen,

  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,

  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  output logic [ID_WIDTH-1:0]     s_bid,

  output logic                    cw_valid,
  input  logic                    cw_ready,
  output logic [ADDR_WIDTH-1:0]   cw_addr,
  output logic [DATA_WIDTH-1:0]   cw_data,
  output logic [DATA_WIDTH/8-1:0] cw_strb,
  output logic                    cw_last
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [1:0]            burst_q;
  logic [2:0]            size_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  oversize_q;
  logic                  awready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;

  logic                  in_data;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic                  wlast_bad;
  logic [1:0]            aw_burst_eff;
  logic                  aw_burst_bad;
  logic                  aw_oversize;

  axi_addr_next #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_next (
    .addr      (addr_q),
    .burst     (burst_q),
    .size      (size_q),
    .len       (len_q),
    .next_addr (addr_nxt)
  );

  // Classify the incoming AW: demote illegal burst types to INCR and flag
  // beats wider than the data bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    aw_burst_eff = s_awburst;
    aw_burst_bad = 1'b0;
    if ((s_awburst == BURST_RSVD) ||
        ((s_awburst == BURST_WRAP) && !wrap_len_ok(s_awlen))) begin
      aw_burst_eff = BURST_INCR;
      aw_burst_bad = 1'b1;
    end
    aw_oversize = (32'd1 << s_awsize) > 32'(STRB_WIDTH);
  end

  // The W path is combinational so a beat can move every cycle; oversize
  // bursts are drained without ever touching the cache.
  assign in_data   = (state == ST_DATA);
  assign last_beat = (cnt_q == 8'd0);
  assign s_wready  = in_data && (oversize_q || cw_ready);
  assign cw_valid  = in_data && s_wvalid && !oversize_q;
  assign cw_addr   = addr_q;
  assign cw_data   = s_wdata;
  assign cw_strb   = s_wstrb;
  assign cw_last   = in_data && last_beat;
  assign aw_hs     = s_awvalid && awready_q;
  assign w_hs      = s_wvalid && s_wready;
  assign wlast_bad = (s_wlast != last_beat);

  assign s_awready = awready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_bid     = bid_q;

  // Burst FSM: capture AW, count beats down to zero, then hold B until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state      <= ST_IDLE;
      addr_q     <= '0;
      id_q       <= '0;
      burst_q    <= '0;
      size_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      oversize_q <= 1'b0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          awready_q <= 1'b1;
          if (aw_hs) begin
            addr_q     <= s_awaddr;
            id_q       <= s_awid;
            burst_q    <= aw_burst_eff;
            size_q     <= s_awsize;
            len_q      <= s_awlen;
            cnt_q      <= s_awlen;
            oversize_q <= aw_oversize;
            err_q      <= aw_burst_bad || aw_oversize;
            awready_q  <= 1'b0;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - 8'd1;
            err_q  <= err_q || wlast_bad;
            if (last_beat) begin
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              state    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_beat_gen.sv
// Randomised scoreboard bench for axi_wr_beat_gen. The driver computes the
// expected cache beats and B response from the burst rules and queues them;
// a negedge monitor pops and compares whenever the DUT hands something over.
module tb_axi_wr_beat_gen;
  import axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_awvalid, s_awready;
  logic [AW-1:0] s_awaddr;
  logic [IW-1:0] s_awid;
  logic [1:0]    s_awburst;
  logic [2:0]    s_awsize;
  logic [7:0]    s_awlen;
  logic          s_wvalid, s_wready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast;
  logic          s_bvalid, s_bready;
  logic [1:0]    s_bresp;
  logic [IW-1:0] s_bid;
  logic          cw_valid, cw_ready;
  logic [AW-1:0] cw_addr;
  logic [DW-1:0] cw_data;
  logic [SW-1:0] cw_strb;
  logic          cw_last;

  always #5 clk = ~clk;

  axi_wr_beat_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awburst(s_awburst), .s_awsize(s_awsize), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_addr(cw_addr),
    .cw_data(cw_data), .cw_strb(cw_strb), .cw_last(cw_last)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    logic [1:0]    resp;
    logic [IW-1:0] id;
  } bexp_t;

  beat_t beat_q[$];
  bexp_t b_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cw_seen  = 0;
  bit in_data  = 1'b0;
  bit cur_over = 1'b0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat address from the burst definition: FIXED stays put, INCR
  // steps linearly, WRAP steps linearly inside its aligned container.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] a, input logic [1:0] b,
                                               input logic [2:0] sz, input logic [7:0] len,
                                               input int i);
    logic [AW-1:0] bytes;
    logic [AW-1:0] total;
    logic [AW-1:0] base;
    bytes = AW'(1) << sz;
    if (b == BURST_FIXED) return a;
    if (b == BURST_WRAP) begin
      total = (AW'(len) + 1) * bytes;
      base  = a - (a % total);
      return base + (((a - base) + AW'(i) * bytes) % total);
    end
    return a + AW'(i) * bytes;
  endfunction

  function automatic bit model_bad_burst(input logic [1:0] b, input logic [7:0] len);
    return (b == 2'b11) || (b == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Cache-ready pattern generator.
  initial begin
    cw_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cw_ready = 1'b1;
        1:       cw_ready = ~cw_ready;
        default: cw_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    beat_t         e;
    bexp_t         be;
    bit            hold_v = 1'b0;
    logic [1:0]    hold_resp = '0;
    logic [IW-1:0] hold_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (!in_data) begin
          check("wready_outside_data", s_wready, 1'b0);
          check("cwvalid_outside_data", cw_valid, 1'b0);
        end else if (cur_over) begin
          check("oversize_wready", s_wready, 1'b1);
          check("oversize_no_cw", cw_valid, 1'b0);
        end else begin
          check("wready_mirrors_cw_ready", s_wready, cw_ready);
        end
        if (cw_valid && cw_ready) begin
          cw_seen++;
          if (beat_q.size() == 0) begin
            check("cw_unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = beat_q.pop_front();
            check("cw_addr", cw_addr, e.addr);
            check("cw_data", cw_data, e.data);
            check("cw_strb", cw_strb, e.strb);
            check("cw_last", cw_last, e.last);
          end
        end
        if (hold_v) check("b_stable", {s_bvalid, s_bresp, s_bid}, {1'b1, hold_resp, hold_id});
        hold_v    = s_bvalid && !s_bready;
        hold_resp = s_bresp;
        hold_id   = s_bid;
        if (s_bvalid && s_bready) begin
          if (b_q.size() == 0) begin
            check("b_unexpected", 1'b1, 1'b0);
          end else begin
            be = b_q.pop_front();
            check("bresp", s_bresp, be.resp);
            check("bid", s_bid, be.id);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    in_data   = 1'b0;
    cur_over  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    beat_q.delete();
    b_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", s_awready, 1'b0);
    check("rst_wready", s_wready, 1'b0);
    check("rst_bvalid", s_bvalid, 1'b0);
    check("rst_cwvalid", cw_valid, 1'b0);
    check("rst_bresp", s_bresp, 2'b00);
    check("rst_bid", s_bid, '0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("awready_after_rst", s_awready, 1'b1);
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [1:0] b,
                         input logic [2:0] sz, input logic [7:0] len, output bit ok);
    int t = 0;
    bit hs = 1'b0;
    s_awvalid = 1'b1;
    s_awaddr  = a;
    s_awid    = id;
    s_awburst = b;
    s_awsize  = sz;
    s_awlen   = len;
    do begin
      @(negedge clk);
      hs = s_awvalid && s_awready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 100);
    s_awvalid = 1'b0;
    check("aw_accept", hs, 1'b1);
    ok = hs;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] st, input logic lst,
                           output bit ok);
    int t = 0;
    bit hs = 1'b0;
    s_wvalid = 1'b1;
    s_wdata  = d;
    s_wstrb  = st;
    s_wlast  = lst;
    do begin
      @(negedge clk);
      hs = s_wvalid && s_wready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 400);
    if (!hs) check("w_accept_timeout", 1'b0, 1'b1);
    ok = hs;
  endtask

  // One complete burst: queue expectations, drive AW, all W beats and B.
  task automatic run_burst(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [1:0] b,
                           input logic [2:0] sz, input logic [7:0] len, input int flip,
                           input int mode);
    bit            bad, over, err, ok, hs;
    logic [1:0]    eff;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    int            t;
    bad  = model_bad_burst(b, len);
    over = (1 << sz) > SW;
    err  = bad || over || (flip >= 0 && flip <= int'(len));
    eff  = bad ? BURST_INCR : b;
    ready_mode = mode;
    b_q.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
    if ($urandom_range(0, 1) == 1) begin
      s_wvalid = 1'b1;  // stray W in IDLE must be ignored
      @(posedge clk);
      #1;
    end
    s_wvalid = 1'b0;
    send_aw(a, id, b, sz, len, ok);
    if (!ok) begin do_reset(); return; end
    in_data  = 1'b1;
    cur_over = over;
    for (int i = 0; i <= int'(len); i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        s_wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      d  = {$urandom, $urandom};
      st = SW'($urandom);
      if (!over) beat_q.push_back('{addr: model_addr(a, eff, sz, len, i), data: d, strb: st,
                                    last: (i == int'(len))});
      send_beat(d, st, (i == int'(len)) ^ (i == flip), ok);
      if (!ok) begin do_reset(); return; end
    end
    in_data  = 1'b0;
    cur_over = 1'b0;
    s_wvalid = 1'($urandom_range(0, 1));  // stray W in RESP must be ignored
    @(negedge clk);
    check("bvalid_latency", s_bvalid, 1'b1);
    @(posedge clk);
    #1;
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk);
      #1;
    end
    s_bready = 1'b1;
    t  = 0;
    hs = 1'b0;
    do begin
      @(negedge clk);
      hs = s_bvalid && s_bready;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 50);
    s_bready = 1'b0;
    s_wvalid = 1'b0;
    check("b_accept", hs, 1'b1);
    if (!hs) begin do_reset(); return; end
    @(negedge clk);
    check("awready_after_b", s_awready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    int            c0;
    logic [1:0]    b;
    logic [2:0]    sz;
    logic [7:0]    len;
    logic [AW-1:0] a;
    int            flip;
    s_awaddr = '0; s_awid = '0; s_awburst = '0; s_awsize = '0; s_awlen = '0;
    s_wdata = '0; s_wstrb = '0;
    do_reset();

    // Directed bursts.
    run_burst(32'h100, 4'h3, BURST_INCR, 3'd3, 8'd3, -1, 0);
    run_burst(32'h38, 4'h6, BURST_WRAP, 3'd3, 8'd3, -1, 0);
    run_burst(32'h40, 4'h9, BURST_FIXED, 3'd3, 8'd2, -1, 1);
    run_burst(32'h300, 4'h2, BURST_INCR, 3'd3, 8'd3, 1, 0);
    c0 = cw_seen;
    run_burst(32'h500, 4'h7, BURST_INCR, 3'd4, 8'd1, -1, 2);
    check("oversize_cw_count", cw_seen - c0, 0);

    // Reset while beat 2 of an 8-beat burst is presented.
    ready_mode = 0;
    beat_q.push_back('{addr: 32'h200, data: 64'h1111, strb: 8'hff, last: 1'b0});
    send_aw(32'h200, 4'h5, BURST_INCR, 3'd3, 8'd7, ok);
    in_data = 1'b1;
    send_beat(64'h1111, 8'hff, 1'b0, ok);
    s_wdata = 64'h2222;
    rst     = 1'b1;
    check("rst_beats_drained", beat_q.size(), 0);
    do_reset();
    repeat (5) begin
      @(negedge clk);
      check("no_b_after_abort", s_bvalid, 1'b0);
    end
    @(posedge clk);
    #1;
    run_burst(32'h600, 4'ha, BURST_INCR, 3'd2, 8'd3, -1, 0);

    // Longest burst, crossing the top of the address space.
    run_burst(32'hffff_fc00, 4'hc, BURST_INCR, 3'd3, 8'd255, -1, 2);

    // Random bursts.
    for (int n = 0; n < 40; n++) begin
      b    = 2'($urandom_range(0, 3));
      sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      len  = 8'($urandom_range(0, 15));
      a    = $urandom;
      if (b == BURST_WRAP) a = a & ~((AW'(1) << sz) - 1);
      flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
      run_burst(a, 4'($urandom), b, sz, len, flip, int'($urandom_range(0, 2)));
    end

    check("beat_queue_empty", beat_q.size(), 0);
    check("b_queue_empty", b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
